// File: rtl/result_collector_if.sv
// rtl/result_collector_if.sv - result capture inputs and drain stream between processor, collector and consumer
//
// Signals:
//   res_data / res_flags / res_ready : processor result, flags and data_ready level
//   out_data / out_valid / out_ready : drain stream carrying {flags, data} words
// Modports:
//   master : processor/consumer side (drives results and out_ready)
//   slave  : collector side (drives out_data/out_valid)
interface result_collector_if #(
  parameter int DATA_W = 16,
  parameter int FLAG_W = 4
);
  logic [DATA_W-1:0]        res_data;
  logic [FLAG_W-1:0]        res_flags;
  logic                     res_ready;
  logic [FLAG_W+DATA_W-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output res_data, res_flags, res_ready, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  res_data, res_flags, res_ready, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/result_collector.sv
// rtl/result_collector.sv - captures processor results on data_ready rising edge into a FWFT FIFO with statistics
//
// Ports:
//   clk, rst_n    : clock and synchronous active-low reset
//   bus (slave)   : res_* capture inputs, out_* drain stream
//   fifo_count    : entries held, 0..DEPTH
//   full          : fifo_count == DEPTH
//   drop_sticky   : a result was lost to a full FIFO since last clear/reset
//   clear_stats   : zero counters and drop_sticky (FIFO untouched)
//   result_cnt / ovf_cnt / zero_cnt / drop_cnt : saturating statistics
module result_collector #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16,
  parameter int FLAG_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  result_collector_if.slave      bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   full,
  output logic                   drop_sticky,
  input  logic                   clear_stats,
  output logic [CNT_W-1:0]       result_cnt,
  output logic [CNT_W-1:0]       ovf_cnt,
  output logic [CNT_W-1:0]       zero_cnt,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = FLAG_W + DATA_W;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             res_ready_q;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] result_cnt_q, result_cnt_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic cap, pop, wr_en, drop;

  // Clear takes effect before the event of the same cycle is counted.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                              input logic clr, input logic ev);
    logic [CNT_W-1:0] base;
    base = clr ? '0 : v;
    if (ev && (base != '1)) base = base + CNT_W'(1);
    return base;
  endfunction

  // data_ready is a level held through COMPLETE; only its rising edge is a result.
  assign cap   = bus.res_ready & ~res_ready_q;
  assign pop   = bus.out_valid & bus.out_ready;
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign wr_en = cap & (~full | pop);
  assign drop  = cap & full & ~pop;

  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = bus.out_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count    = count_q;
  assign drop_sticky   = sticky_q;
  assign result_cnt    = result_cnt_q;
  assign ovf_cnt       = ovf_cnt_q;
  assign zero_cnt      = zero_cnt_q;
  assign drop_cnt      = drop_cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_en, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase

    sticky_d     = (clear_stats ? 1'b0 : sticky_q) | drop;
    result_cnt_d = sat_inc(result_cnt_q, clear_stats, wr_en);
    ovf_cnt_d    = sat_inc(ovf_cnt_q, clear_stats, wr_en & bus.res_flags[3]);
    zero_cnt_d   = sat_inc(zero_cnt_q, clear_stats, wr_en & bus.res_flags[2]);
    drop_cnt_d   = sat_inc(drop_cnt_q, clear_stats, drop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      // Treat data_ready as already high so a result pending at release is ignored.
      res_ready_q  <= 1'b1;
      sticky_q     <= 1'b0;
      result_cnt_q <= '0;
      ovf_cnt_q    <= '0;
      zero_cnt_q   <= '0;
      drop_cnt_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      res_ready_q  <= bus.res_ready;
      sticky_q     <= sticky_d;
      result_cnt_q <= result_cnt_d;
      ovf_cnt_q    <= ovf_cnt_d;
      zero_cnt_q   <= zero_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Storage needs no reset: out_data is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem_q[wr_ptr_q] <= {bus.res_flags, bus.res_data};
  end

endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Downstream stage of the time-based processor; consumes its data_out / status_flags / data_ready outputs.
- The processor holds data_ready high for the whole COMPLETE state, so this block captures each result exactly once on the rising edge of data_ready.
- Each capture is buffered as a {flags, result} word in a small FIFO. The FIFO drains through a valid/ready stream to the next consumer.
- The block also keeps per-run statistics counters (results, overflows, zeros, drops).

Parameters:
DEPTH, 8, FIFO entries; power of 2, min 2
DATA_W, 16, result width; matches processor data_out
FLAG_W, 4, flag width; bit3 overflow, bit2 zero, bit1 reserved, bit0 complete
CNT_W, 16, width of each statistics counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
res_data  in  DATA_W  processor data_out
res_flags  in  FLAG_W  processor status_flags
res_ready  in  1  processor data_ready
out_data  out  FLAG_W+DATA_W  head entry {flags, data}; flags in MSBs
out_valid  out  1  head entry present
out_ready  in  1  consumer accepts head this cycle
fifo_count  out  $clog2(DEPTH)+1  entries held, 0..DEPTH
full  out  1  fifo_count == DEPTH
drop_sticky  out  1  set on any dropped result; cleared by clear_stats or reset
clear_stats  in  1  synchronous clear of counters and drop_sticky
result_cnt  out  CNT_W  results captured (written into FIFO)
ovf_cnt  out  CNT_W  captured results with flags[3]=1
zero_cnt  out  CNT_W  captured results with flags[2]=1
drop_cnt  out  CNT_W  results lost because FIFO was full

Behaviour:
- Single clock, all state on rising clk. Reset is synchronous, active-low, sampled on clk only.
- Reset values:
  - out_valid=0, fifo_count=0, full=0, drop_sticky=0, all counters=0.
  - Read/write pointers=0. out_data=0 when empty.
  - Internal res_ready_q=1, so a res_ready level already high at reset release is not captured.
- Capture event: cap = res_ready & ~res_ready_q. res_ready_q <= res_ready every cycle. res_data and res_flags are sampled in the cap cycle.
- Pop: pop = out_valid & out_ready. out_data is stable while out_valid=1 and out_ready=0.
- Write decision in a cap cycle:
  - Not full: write, wr_ptr++.
  - Full and pop in the same cycle: write (slot freed by pop), count stays DEPTH.
  - Full and no pop: drop. drop_cnt++, drop_sticky<=1, FIFO unchanged.
- Occupancy:
  - fifo_count +1 on write only, -1 on pop only, unchanged on write+pop.
  - Pointers wrap modulo DEPTH.
- FIFO is first-word-fall-through:
  - A write in cycle N into an empty FIFO gives out_valid=1 and out_data=that entry in cycle N+1.
  - Capture-to-output latency is 1 cycle.
- Pop when empty is impossible by construction (out_valid=0); out_ready is ignored when empty.
- Counters:
  - result_cnt++ on every write; ovf_cnt / zero_cnt ++ on writes with the matching flag bit.
  - All counters saturate at 2^CNT_W-1; no wrap.
- clear_stats:
  - Zeroes counters and drop_sticky; FIFO contents, pointers and fifo_count are untouched.
  - clear_stats together with cap: clear applies first, then the event counts, so the affected counter reads 1.
- Reset mid-operation: FIFO contents are discarded and all outputs return to reset values next cycle. A result already in COMPLETE on the processor side is not re-captured (res_ready_q=1).
- Back-to-back processor results are at least 4 cycles apart. The block still handles cap on every cycle in which res_ready rises.

Test Plan:
- Reset, then processor ADD 0x30+0x12: res_ready rises with res_data=0x0042, res_flags=0x1 -> next cycle out_valid=1, out_data=0x10042, result_cnt=1, fifo_count=1.
- res_ready held high 10 cycles with out_ready=0 -> exactly one entry, fifo_count=1, result_cnt=1.
- Nine captures with out_ready=0, DEPTH=8 -> full=1 after the 8th; 9th dropped: drop_cnt=1, drop_sticky=1, fifo_count=8. Drain yields the first 8 entries in order.
- FIFO full, 9th capture with out_ready=1 in the same cycle -> no drop, fifo_count stays 8, head advances, 9th entry appears last.
- Captures with flags 0x9 (MUL overflow) and 0x5 (COMPARE equal) -> ovf_cnt=1, zero_cnt=1. clear_stats asserted together with a third capture (flags 0x1) -> result_cnt=1, ovf_cnt=0, zero_cnt=0, FIFO still holds 3 entries.
- rst_n low for 1 cycle with 3 entries stored and res_ready high -> fifo_count=0, out_valid=0, counters 0. No capture after release until res_ready falls and rises again.
